// File: rtl/led_pixel_engine.sv
// Per-pixel colour engine: colour mode -> animation fade -> master dimmer,
// one channel at a time, with the pixel config snapshotted on request accept.
module led_pixel_engine #(
    parameter int NUM_CH     = 3,
    parameter int CW         = 8,
    parameter int IDX_W      = 8,
    parameter int NUM_LEDS   = 50,
    parameter int PROX_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [2:0]           colmode,
    input  logic [IDX_W-1:0]     blocksize,
    input  logic [NUM_CH*CW-1:0] usera,
    input  logic [NUM_CH*CW-1:0] userb,
    input  logic [CW-1:0]        masterfader,
    input  logic [7:0]           animcount,
    input  logic [7:0]           stepclock,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [IDX_W-1:0]     req_index,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [NUM_CH*CW-1:0] pix_data,
    output logic                 busy
);

    localparam int PW2 = 2 * CW;
    localparam int TW  = (2 * IDX_W + 1 > CW) ? 2 * IDX_W + 1 : CW;
    localparam logic [CW-1:0] M   = {CW{1'b1}};
    localparam logic [31:0]   THR = 32'(1) << (CW + PROX_SHIFT);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_PROX, S_COL, S_FADE, S_DIM, S_OUT
    } state_t;

    state_t state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic       req_ready_q, req_ready_d;
    logic       pix_valid_q, pix_valid_d;

    // snapshot of the request and its config
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [1:0]                  mode_q, mode_d;
    logic [2:0]                  colmode_q, colmode_d;
    logic [IDX_W-1:0]            bs_q, bs_d;
    logic [NUM_CH-1:0][CW-1:0]   ua_q, ua_d;
    logic [NUM_CH-1:0][CW-1:0]   ub_q, ub_d;
    logic [CW-1:0]               mf_q, mf_d;
    logic [7:0]                  ac_q, ac_d;
    logic [7:0]                  sc_q, sc_d;

    // per-pixel intermediates
    logic [CW-1:0]               t_q, t_d;
    logic [15:0]                 dist_q, dist_d;
    logic [1:0]                  ci_q, ci_d;
    logic [CW-1:0]               prox_q, prox_d;
    logic [CW-1:0]               c_q, c_d;
    logic [NUM_CH-1:0][CW-1:0]   pix_q, pix_d;

    // combinational helpers
    logic [TW-1:0]  t_sum;
    logic [15:0]    f16, p16, dist_w, dsh;
    logic [1:0]     ci_w;
    logic [CW-1:0]  prox_w;
    logic [PW2-1:0] grad_sum;
    logic [CW-1:0]  col_w, fade_w;
    logic [3:0]     step_mask;
    logic [CW-1:0]  mul_b, mul_res;
    logic [PW2-1:0] mul_p;

    assign req_ready = req_ready_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_q;
    assign busy      = (state_q != S_IDLE);

    // PREP/PROX arithmetic: gradient position, fade distance, step colour index, proximity
    always_comb begin
        t_sum  = TW'(idx_q) * TW'(bs_q) + ((colmode_q == 3'd3) ? TW'(ac_q) : TW'(idx_q));
        f16    = 16'(32'(ac_q) * (NUM_LEDS + 5));
        p16    = 16'(32'(idx_q) << 8);
        dist_w = (f16 >= p16) ? f16 - p16 : p16 - f16;
        // only the low two bits of the sum matter, so idx wraps mod 4 with stepclock
        ci_w   = 2'(sc_q + {6'b0, idx_q[1:0]});
        dsh    = dist_q >> PROX_SHIFT;
        prox_w = '0;
        if (32'(dist_q) < THR && dsh <= 16'(M))
            prox_w = M - CW'(dsh);
    end

    // channel colour, shared FADE/DIM multiplier and fade selection
    always_comb begin
        grad_sum = PW2'(ua_q[ch_q]) * PW2'(t_q) + PW2'(ub_q[ch_q]) * PW2'(M - t_q);
        case (ci_q)
            2'd0:    step_mask = 4'b0001;
            2'd1:    step_mask = 4'b0010;
            2'd2:    step_mask = 4'b0100;
            default: step_mask = 4'b0011;
        endcase
        case (colmode_q)
            3'd0:       col_w = ua_q[ch_q];
            3'd1:       col_w = ub_q[ch_q];
            3'd2, 3'd3: col_w = CW'(grad_sum >> CW);
            3'd4:       col_w = step_mask[ch_q] ? M : '0;
            default:    col_w = '0;
        endcase
        mul_b = mf_q;
        if (state_q == S_FADE)
            mul_b = (mode_q == 2'd2) ? M - prox_q : prox_q;
        mul_p   = PW2'(c_q) * PW2'(mul_b);
        mul_res = CW'(mul_p >> CW);
        case (mode_q)
            2'd0:       fade_w = c_q;
            2'd1, 2'd2: fade_w = mul_res;
            default:    fade_w = '0;
        endcase
    end

    // FSM next state plus registered handshake outputs
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: if (req_valid && req_ready_q) state_d = S_PREP;
            S_PREP: state_d = S_PROX;
            S_PROX: begin
                state_d = S_COL;
                ch_d    = '0;
            end
            S_COL:  state_d = S_FADE;
            S_FADE: state_d = S_DIM;
            S_DIM: begin
                if (ch_q == 2'(NUM_CH - 1)) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_COL;
                    ch_d    = ch_q + 2'd1;
                end
            end
            S_OUT:   if (pix_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        pix_valid_d = (state_d == S_OUT);
    end

    // datapath register updates per state
    always_comb begin
        idx_d     = idx_q;
        mode_d    = mode_q;
        colmode_d = colmode_q;
        bs_d      = bs_q;
        ua_d      = ua_q;
        ub_d      = ub_q;
        mf_d      = mf_q;
        ac_d      = ac_q;
        sc_d      = sc_q;
        t_d       = t_q;
        dist_d    = dist_q;
        ci_d      = ci_q;
        prox_d    = prox_q;
        c_d       = c_q;
        pix_d     = pix_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    idx_d     = req_index;
                    mode_d    = mode;
                    colmode_d = colmode;
                    bs_d      = blocksize;
                    ua_d      = usera;
                    ub_d      = userb;
                    mf_d      = masterfader;
                    ac_d      = animcount;
                    sc_d      = stepclock;
                end
            end
            S_PREP: begin
                t_d    = CW'(t_sum);
                dist_d = dist_w;
                ci_d   = ci_w;
            end
            S_PROX:  prox_d = prox_w;
            S_COL:   c_d = col_w;
            S_FADE:  c_d = fade_w;
            S_DIM:   pix_d[ch_q] = mul_res;
            default: ;
        endcase
    end

    // state register; async reset aborts any pixel in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            req_ready_q <= 1'b0;
            pix_valid_q <= 1'b0;
            idx_q       <= '0;
            mode_q      <= '0;
            colmode_q   <= '0;
            bs_q        <= '0;
            ua_q        <= '0;
            ub_q        <= '0;
            mf_q        <= '0;
            ac_q        <= '0;
            sc_q        <= '0;
            t_q         <= '0;
            dist_q      <= '0;
            ci_q        <= '0;
            prox_q      <= '0;
            c_q         <= '0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            req_ready_q <= req_ready_d;
            pix_valid_q <= pix_valid_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            colmode_q   <= colmode_d;
            bs_q        <= bs_d;
            ua_q        <= ua_d;
            ub_q        <= ub_d;
            mf_q        <= mf_d;
            ac_q        <= ac_d;
            sc_q        <= sc_d;
            t_q         <= t_d;
            dist_q      <= dist_d;
            ci_q        <= ci_d;
            prox_q      <= prox_d;
            c_q         <= c_d;
            pix_q       <= pix_d;
        end
    end

endmodule
